// File: rtl/gpr_commit_sched_pkg.sv
// Shared widths for the commit scheduler, plus the queue entry type and the lane store rule.
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif
`ifndef GPR_ADDR_WIDTH
`define GPR_ADDR_WIDTH 5
`endif
`ifndef COMMIT_Q_DEPTH
`define COMMIT_Q_DEPTH 4
`endif

package gpr_commit_sched_pkg;

  localparam int WORD_W        = `WORD_WIDTH;
  localparam int ADDR_W        = `GPR_ADDR_WIDTH;
  localparam int COMMIT_QDEPTH = `COMMIT_Q_DEPTH;

  // One pending register-file write.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [WORD_W-1:0] value;
  } commit_entry_t;

  // A fired lane only occupies a queue slot if it really writes a non-zero register.
  function automatic logic lane_stores(input logic              fire,
                                       input logic              wb_en,
                                       input logic [ADDR_W-1:0] addr);
    return fire & wb_en & (addr != '0);
  endfunction

endpackage

// File: rtl/gpr_commit_sched_commit_q_fwd.sv
// Combinational youngest-match search over the commit queue for one operand address.
module commit_q_fwd
  import gpr_commit_sched_pkg::*;
#(
  parameter int  QDEPTH = COMMIT_QDEPTH,
  localparam int PTR_W  = $clog2(QDEPTH)
) (
  input  commit_entry_t [QDEPTH-1:0] entries_i,
  input  logic [QDEPTH-1:0]          valid_i,
  input  logic [PTR_W-1:0]           rd_ptr_i,
  input  logic [ADDR_W-1:0]          addr_i,
  output logic                       hit_o,
  output logic [WORD_W-1:0]          value_o
);

  // Walk from the head (oldest) towards the tail; a later match overrides, leaving the youngest.
  always_comb begin
    hit_o   = 1'b0;
    value_o = '0;
    for (int k = 0; k < QDEPTH; k++) begin
      if (valid_i[rd_ptr_i + PTR_W'(k)] &&
          (entries_i[rd_ptr_i + PTR_W'(k)].addr == addr_i) &&
          (addr_i != '0)) begin
        hit_o   = 1'b1;
        value_o = entries_i[rd_ptr_i + PTR_W'(k)].value;
      end
    end
  end

endmodule

// File: rtl/gpr_commit_sched.sv
// Retirement scheduler: up to two ROB retires per cycle into an in-order queue that drains
// one write per cycle into the register file, with read-stage forwarding from queued entries.
module gpr_commit_sched
  import gpr_commit_sched_pkg::*;
#(
  parameter int QDEPTH = COMMIT_QDEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rob_c0_valid,
  input  logic              rob_c0_wb_en,
  input  logic [ADDR_W-1:0] rob_c0_dst_addr,
  input  logic [WORD_W-1:0] rob_c0_dst_value,
  output logic              rob_c0_ready,
  input  logic              rob_c1_valid,
  input  logic              rob_c1_wb_en,
  input  logic [ADDR_W-1:0] rob_c1_dst_addr,
  input  logic [WORD_W-1:0] rob_c1_dst_value,
  output logic              rob_c1_ready,
  output logic              commit_en,
  output logic [ADDR_W-1:0] commit_dst_addr,
  output logic [WORD_W-1:0] commit_dst_value,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  output logic              rs1_fwd_hit,
  output logic              rs2_fwd_hit,
  output logic [WORD_W-1:0] rs1_fwd_value,
  output logic [WORD_W-1:0] rs2_fwd_value,
  output logic              queue_empty
);

  localparam int PTR_W = $clog2(QDEPTH);
  localparam int CNT_W = PTR_W + 1;

  commit_entry_t [QDEPTH-1:0] mem_q, mem_d;
  logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]           count_q, count_d;
  logic                       fire0, fire1, store0, store1, drain;
  logic [QDEPTH-1:0]          valid_mask;

  // Ready looks only at the registered count, so a same-cycle drain never opens a slot early.
  assign rob_c0_ready = (count_q <= CNT_W'(QDEPTH - 1));
  assign rob_c1_ready = (count_q <= CNT_W'(QDEPTH - 2));

  // The head is presented straight from storage; nothing from the rob_* inputs reaches it.
  assign commit_en        = (count_q != '0);
  assign commit_dst_addr  = commit_en ? mem_q[rd_ptr_q].addr  : '0;
  assign commit_dst_value = commit_en ? mem_q[rd_ptr_q].value : '0;
  assign queue_empty      = (count_q == '0);

  // A slot is live when its distance from the head is below the occupancy.
  for (genvar gi = 0; gi < QDEPTH; gi++) begin : g_valid
    logic [PTR_W-1:0] age;
    assign age            = PTR_W'(gi) - rd_ptr_q;
    assign valid_mask[gi] = (CNT_W'(age) < count_q);
  end

  // Accept lanes, append stored writes in lane order, and retire the head once per cycle.
  always_comb begin
    fire0  = rob_c0_valid & rob_c0_ready;
    fire1  = rob_c1_valid & rob_c1_ready & fire0;
    store0 = lane_stores(fire0, rob_c0_wb_en, rob_c0_dst_addr);
    store1 = lane_stores(fire1, rob_c1_wb_en, rob_c1_dst_addr);
    drain  = commit_en;

    mem_d = mem_q;
    if (store0) begin
      mem_d[wr_ptr_q] = '{addr: rob_c0_dst_addr, value: rob_c0_dst_value};
    end
    if (store1) begin
      // Lane1 lands behind lane0 when both store, otherwise it takes the tail slot itself.
      mem_d[wr_ptr_q + PTR_W'(store0)] = '{addr: rob_c1_dst_addr, value: rob_c1_dst_value};
    end

    wr_ptr_d = wr_ptr_q + PTR_W'(store0) + PTR_W'(store1);
    rd_ptr_d = rd_ptr_q + PTR_W'(drain);
    count_d  = count_q + CNT_W'(store0) + CNT_W'(store1) - CNT_W'(drain);
  end

  // Queue state; reset discards everything immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  commit_q_fwd #(.QDEPTH(QDEPTH)) u_fwd_rs1 (
    .entries_i (mem_q),
    .valid_i   (valid_mask),
    .rd_ptr_i  (rd_ptr_q),
    .addr_i    (rs1_addr),
    .hit_o     (rs1_fwd_hit),
    .value_o   (rs1_fwd_value)
  );

  commit_q_fwd #(.QDEPTH(QDEPTH)) u_fwd_rs2 (
    .entries_i (mem_q),
    .valid_i   (valid_mask),
    .rd_ptr_i  (rd_ptr_q),
    .addr_i    (rs2_addr),
    .hit_o     (rs2_fwd_hit),
    .value_o   (rs2_fwd_value)
  );

endmodule

// File: tb/tb_gpr_commit_sched.sv
// Bench for gpr_commit_sched: directed table, hand sequences for fill and reset, random traffic
// checked against a queue-based reference model.
module tb_gpr_commit_sched;
  import gpr_commit_sched_pkg::*;

  localparam int QD = COMMIT_QDEPTH;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              c0_valid, c0_wb_en, c1_valid, c1_wb_en;
  logic [ADDR_W-1:0] c0_addr, c1_addr, rs1_addr, rs2_addr;
  logic [WORD_W-1:0] c0_value, c1_value;
  logic              c0_ready, c1_ready, commit_en, queue_empty;
  logic              rs1_fwd_hit, rs2_fwd_hit;
  logic [ADDR_W-1:0] commit_dst_addr;
  logic [WORD_W-1:0] commit_dst_value, rs1_fwd_value, rs2_fwd_value;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  gpr_commit_sched dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .rob_c0_valid     (c0_valid),
    .rob_c0_wb_en     (c0_wb_en),
    .rob_c0_dst_addr  (c0_addr),
    .rob_c0_dst_value (c0_value),
    .rob_c0_ready     (c0_ready),
    .rob_c1_valid     (c1_valid),
    .rob_c1_wb_en     (c1_wb_en),
    .rob_c1_dst_addr  (c1_addr),
    .rob_c1_dst_value (c1_value),
    .rob_c1_ready     (c1_ready),
    .commit_en        (commit_en),
    .commit_dst_addr  (commit_dst_addr),
    .commit_dst_value (commit_dst_value),
    .rs1_addr         (rs1_addr),
    .rs2_addr         (rs2_addr),
    .rs1_fwd_hit      (rs1_fwd_hit),
    .rs2_fwd_hit      (rs2_fwd_hit),
    .rs1_fwd_value    (rs1_fwd_value),
    .rs2_fwd_value    (rs2_fwd_value),
    .queue_empty      (queue_empty)
  );

  // Directed vector: inputs for one cycle and the outputs expected before that cycle's edge.
  typedef struct {
    logic              c0v, c0w, c1v, c1w;
    logic [ADDR_W-1:0] c0a, c1a, rs1;
    logic [WORD_W-1:0] c0d, c1d;
    logic              e_r0, e_r1, e_ce, e_emp, e_h1;
    logic [ADDR_W-1:0] e_ca;
    logic [WORD_W-1:0] e_cd, e_v1;
  } vec_t;

  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [WORD_W-1:0] v;
  } ment_t;

  ment_t             mq[$];
  logic [ADDR_W-1:0] log_a[$];
  logic [WORD_W-1:0] log_v[$];
  logic              last_r1;
  vec_t              vecs[13];

  function automatic vec_t mk(input int c0v, input int c0w, input int c0a, input int c0d,
                              input int c1v, input int c1w, input int c1a, input int c1d,
                              input int rs1, input int r0, input int r1, input int ce,
                              input int ca, input int cd, input int emp, input int h1,
                              input int v1);
    vec_t v;
    v.c0v = 1'(c0v); v.c0w = 1'(c0w); v.c0a = ADDR_W'(c0a); v.c0d = WORD_W'(c0d);
    v.c1v = 1'(c1v); v.c1w = 1'(c1w); v.c1a = ADDR_W'(c1a); v.c1d = WORD_W'(c1d);
    v.rs1 = ADDR_W'(rs1);
    v.e_r0 = 1'(r0); v.e_r1 = 1'(r1); v.e_ce = 1'(ce); v.e_ca = ADDR_W'(ca);
    v.e_cd = WORD_W'(cd); v.e_emp = 1'(emp); v.e_h1 = 1'(h1); v.e_v1 = WORD_W'(v1);
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic drive(input logic v0, input logic w0, input int a0, input int d0,
                       input logic v1, input logic w1, input int a1, input int d1,
                       input int r1, input int r2);
    c0_valid = v0; c0_wb_en = w0; c0_addr = ADDR_W'(a0); c0_value = WORD_W'(d0);
    c1_valid = v1; c1_wb_en = w1; c1_addr = ADDR_W'(a1); c1_value = WORD_W'(d1);
    rs1_addr = ADDR_W'(r1); rs2_addr = ADDR_W'(r2);
  endtask

  // Youngest queued value for an address, searched from the tail of the model queue.
  task automatic model_fwd(input logic [ADDR_W-1:0] a, output logic hit, output logic [WORD_W-1:0] val);
    hit = 1'b0;
    val = '0;
    for (int i = mq.size() - 1; i >= 0; i--) begin
      if (a != '0 && mq[i].a == a) begin
        hit = 1'b1;
        val = mq[i].v;
        break;
      end
    end
  endtask

  // One clock cycle with the inputs already driven: compare against the model, then step it.
  task automatic model_cycle();
    logic r0, r1, f0, f1, h1, h2;
    logic [WORD_W-1:0] v1, v2;
    @(negedge clk);
    r0 = (mq.size() <= QD - 1);
    r1 = (mq.size() <= QD - 2);
    chk("c0_ready", c0_ready, r0);
    chk("c1_ready", c1_ready, r1);
    chk("commit_en", commit_en, mq.size() != 0);
    chk("queue_empty", queue_empty, mq.size() == 0);
    chk("commit_addr", commit_dst_addr, (mq.size() != 0) ? mq[0].a : '0);
    chk("commit_value", commit_dst_value, (mq.size() != 0) ? mq[0].v : '0);
    model_fwd(rs1_addr, h1, v1);
    model_fwd(rs2_addr, h2, v2);
    chk("rs1_hit", rs1_fwd_hit, h1);
    chk("rs2_hit", rs2_fwd_hit, h2);
    if (h1) chk("rs1_value", rs1_fwd_value, v1);
    if (h2) chk("rs2_value", rs2_fwd_value, v2);
    last_r1 = c1_ready;
    if (commit_en) begin
      log_a.push_back(commit_dst_addr);
      log_v.push_back(commit_dst_value);
      $display("commit addr=%0d value=0x%0h", commit_dst_addr, commit_dst_value);
    end
    f0 = c0_valid & r0;
    f1 = c1_valid & r1 & f0;
    @(posedge clk);
    if (mq.size() != 0) void'(mq.pop_front());
    if (f0 && c0_wb_en && c0_addr != '0) mq.push_back('{a: c0_addr, v: c0_value});
    if (f1 && c1_wb_en && c1_addr != '0) mq.push_back('{a: c1_addr, v: c1_value});
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 0, 5, 5);

    // Reset state.
    #12;
    chk("rst_commit_en", commit_en, 0);
    chk("rst_commit_addr", commit_dst_addr, 0);
    chk("rst_commit_value", commit_dst_value, 0);
    chk("rst_queue_empty", queue_empty, 1);
    chk("rst_rs1_hit", rs1_fwd_hit, 0);
    chk("rst_c0_ready", c0_ready, 1);
    chk("rst_c1_ready", c1_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed table: single commit, dual WAW with forwarding, drops, lane order, lane1-only store.
    vecs[0]  = mk(1, 1, 5, 'hDEADBEEF, 0, 0, 0, 0,    5, 1, 1, 0, 0, 0,          1, 0, 0);
    vecs[1]  = mk(0, 0, 0, 0,          0, 0, 0, 0,    5, 1, 1, 1, 5, 'hDEADBEEF, 0, 1, 'hDEADBEEF);
    vecs[2]  = mk(0, 0, 0, 0,          0, 0, 0, 0,    5, 1, 1, 0, 0, 0,          1, 0, 0);
    vecs[3]  = mk(1, 1, 3, 'h11,       1, 1, 3, 'h22, 3, 1, 1, 0, 0, 0,          1, 0, 0);
    vecs[4]  = mk(0, 0, 0, 0,          0, 0, 0, 0,    3, 1, 1, 1, 3, 'h11,       0, 1, 'h22);
    vecs[5]  = mk(0, 0, 0, 0,          0, 0, 0, 0,    3, 1, 1, 1, 3, 'h22,       0, 1, 'h22);
    vecs[6]  = mk(1, 1, 0, 'hFF,       1, 0, 7, 'h77, 7, 1, 1, 0, 0, 0,          1, 0, 0);
    vecs[7]  = mk(0, 0, 0, 0,          0, 0, 0, 0,    7, 1, 1, 0, 0, 0,          1, 0, 0);
    vecs[8]  = mk(0, 1, 9, 'h98,       1, 1, 9, 'h99, 9, 1, 1, 0, 0, 0,          1, 0, 0);
    vecs[9]  = mk(0, 0, 0, 0,          0, 0, 0, 0,    9, 1, 1, 0, 0, 0,          1, 0, 0);
    vecs[10] = mk(1, 0, 4, 'h44,       1, 1, 6, 'h66, 6, 1, 1, 0, 0, 0,          1, 0, 0);
    vecs[11] = mk(0, 0, 0, 0,          0, 0, 0, 0,    6, 1, 1, 1, 6, 'h66,       0, 1, 'h66);
    vecs[12] = mk(0, 0, 0, 0,          0, 0, 0, 0,    6, 1, 1, 0, 0, 0,          1, 0, 0);

    for (int i = 0; i < 13; i++) begin
      c0_valid = vecs[i].c0v; c0_wb_en = vecs[i].c0w; c0_addr = vecs[i].c0a; c0_value = vecs[i].c0d;
      c1_valid = vecs[i].c1v; c1_wb_en = vecs[i].c1w; c1_addr = vecs[i].c1a; c1_value = vecs[i].c1d;
      rs1_addr = vecs[i].rs1; rs2_addr = '0;
      @(negedge clk);
      $display("vector %0d: commit_en=%0d addr=%0d value=0x%0h", i, commit_en, commit_dst_addr, commit_dst_value);
      chk("vec_c0_ready", c0_ready, vecs[i].e_r0);
      chk("vec_c1_ready", c1_ready, vecs[i].e_r1);
      chk("vec_commit_en", commit_en, vecs[i].e_ce);
      chk("vec_commit_addr", commit_dst_addr, vecs[i].e_ca);
      chk("vec_commit_value", commit_dst_value, vecs[i].e_cd);
      chk("vec_queue_empty", queue_empty, vecs[i].e_emp);
      chk("vec_rs1_hit", rs1_fwd_hit, vecs[i].e_h1);
      if (vecs[i].e_h1) chk("vec_rs1_value", rs1_fwd_value, vecs[i].e_v1);
      chk("vec_rs2_zero_hit", rs2_fwd_hit, 0);
      @(posedge clk);
      #1;
    end

    // Fill: dual retires held for three cycles; lane1 must stall once count reaches 3.
    mq.delete();
    log_a.delete();
    log_v.delete();
    drive(1, 1, 1, 'hA1, 1, 1, 2, 'hA2, 1, 2);
    model_cycle();
    drive(1, 1, 3, 'hA3, 1, 1, 4, 'hA4, 3, 4);
    model_cycle();
    drive(1, 1, 5, 'hA5, 1, 1, 6, 'hA6, 4, 5);
    model_cycle();
    chk("full_c1_ready", last_r1, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 5, 6);
    for (int i = 0; i < 6; i++) model_cycle();
    chk("full_commit_count", log_a.size(), 5);
    for (int i = 0; i < 5 && i < log_a.size(); i++) begin
      chk("full_order_addr", log_a[i], i + 1);
      chk("full_order_value", log_v[i], 'hA1 + i);
    end

    // Random traffic against the reference model.
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0, $urandom_range(0, 7), $urandom,
            $urandom_range(0, 2) != 0, $urandom_range(0, 4) != 0, $urandom_range(0, 7), $urandom,
            $urandom_range(0, 7), $urandom_range(0, 7));
      model_cycle();
    end

    // Reset while the queue holds three entries: commits stop at once and nothing survives.
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) model_cycle();
    drive(1, 1, 10, 'hB0, 1, 1, 11, 'hB1, 10, 11);
    model_cycle();
    drive(1, 1, 12, 'hB2, 1, 1, 13, 'hB3, 12, 13);
    model_cycle();
    chk("pre_reset_count3", mq.size(), 3);
    chk("pre_reset_commit_en", commit_en, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 12, 13);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_commit_en", commit_en, 0);
    chk("midrst_queue_empty", queue_empty, 1);
    @(posedge clk);
    #1;
    chk("midrst_edge_commit_en", commit_en, 0);
    mq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("postrst_queue_empty", queue_empty, 1);
    chk("postrst_c0_ready", c0_ready, 1);
    chk("postrst_c1_ready", c1_ready, 1);
    chk("postrst_rs1_hit", rs1_fwd_hit, 0);
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) model_cycle();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
